vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Upstream raster source for the VGA colour path. Runs free from clk (25 MHz nominal) and produces the pixel position.
// - Also produces hsync, vsync, a visible window, line and frame strobes, and a frame counter.
// - The pattern generator consumes hpos/vpos/visible; the RGB444 temporal dither stage consumes frame_start to re-seed its threshold.
// PARAMETERS
// - H_ACTIVE   640  visible pixels per line
// - H_FP       16   horizontal front porch, pixels
// - H_SYNC     96   hsync width, pixels
// - H_BP       48   horizontal back porch, pixels
// - V_ACTIVE   480  visible lines per frame
// - V_FP       10   vertical front porch, lines
// - V_SYNC     2    vsync width, lines
// - V_BP       33   vertical back porch, lines
// - SYNC_POL   0    sync active level (0 = active-low, VGA 640x480 standard)
// - POS_W      10   width of hpos/vpos
// - FRAME_W    8    width of frame_count
// PORTS
// - clk          in   1        pixel clock
// - rst_n        in   1        reset, synchronous, active-low
// - ena          in   1        pixel advance enable; when low, all state holds
// - hpos         out  POS_W    horizontal position, 0..H_TOTAL-1
// - vpos         out  POS_W    vertical position, 0..V_TOTAL-1
// - hsync        out  1        horizontal sync, level SYNC_POL when active
// - vsync        out  1        vertical sync, level SYNC_POL when active
// - visible      out  1        hpos<H_ACTIVE && vpos<V_ACTIVE
// - line_start   out  1        1-cycle strobe on entering hpos==0
// - frame_start  out  1        1-cycle strobe on entering (0,0)
// - frame_count  out  FRAME_W  frames started, mod 2^FRAME_W
// BEHAVIOUR
// - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
// - Elaboration error if either total exceeds 2^POS_W.
// - All outputs are registered. hsync, vsync and visible are computed from the next position and registered in the same edge, so they always match the hpos/vpos presented.
// - Reset values (while rst_n low at clk edge): hpos=H_TOTAL-1, vpos=V_TOTAL-1, hsync=vsync=~SYNC_POL, visible=0, line_start=frame_start=0, frame_count=all ones.
// - First enabled cycle after reset enters (0,0): frame_start=1, line_start=1, frame_count=0.
// - Advance, at a clk edge with ena=1:
//   - hpos==H_TOTAL-1 -> hpos=0. Then vpos wraps to 0 if vpos==V_TOTAL-1, else vpos+1.
//   - Otherwise hpos+1.
// - hsync active for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
// - vsync active for vpos in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), over whole lines.
// - Strobes are set only by an enabled advance into the strobe position and cleared at the next clk edge regardless of ena. A stall never widens a strobe.
// - frame_count increments on every entry to (0,0) and wraps 2^FRAME_W-1 -> 0.
// - ena=0: positions, syncs, visible and frame_count hold.
// - Reset mid-frame overrides ena and takes effect at the next edge.
// STRUCTURE
// - Package vga_timing_pkg:
//   - 640x480@60 porch/sync/active localparams
//   - H_TOTAL, V_TOTAL
//   - typedef pos_t (POS_W)
//   - sync polarity constant
// - Sub-module vga_axis_counter (params ACTIVE, FP, SYNC, BP, W). Instantiated twice:
//   - horizontal: advance=ena
//   - vertical: advance=ena && h_wrap
// - Each instance outputs pos, sync_next, active_next and wrap.
// - The top level adds frame_count, the strobes and the output registers.
// TESTING
// - Reset, then 1 enabled cycle -> hpos=0, vpos=0, visible=1, line_start=1, frame_start=1, frame_count=0, hsync=vsync=1.
// - Horizontal edges:
//   - hpos 639 -> visible=1; hpos 640 -> visible=0.
//   - hpos 655 -> hsync=1; 656 -> hsync=0; 751 -> 0; 752 -> 1.
// - Line and frame wrap:
//   - (799,10) -> (0,11) with line_start for exactly 1 cycle.
//   - vsync=0 only for vpos 490..491.
//   - (799,524) -> (0,0) with frame_start=1 and frame_count+1.
//   - 420000 enabled cycles between frame_starts.
// - ena alternating 1/0 -> 840000 clk cycles per frame; line_start/frame_start stay 1 cycle wide; state holds on ena=0 cycles.
// - rst_n low for 1 cycle at (300,200) -> reset values next edge; next enabled cycle -> (0,0) and frame_start.
// - 256 frames with FRAME_W=8 -> frame_count 255 -> 0. Repeat with SYNC_POL=1 -> sync levels inverted, timing identical.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 raster constants and helpers for the VGA timing slice.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_POS_W    = 10;
  localparam int VGA_FRAME_W  = 8;

  // 0 = active-low syncs, as the 640x480 mode expects
  localparam logic VGA_SYNC_POL = 1'b0;

  typedef logic [VGA_POS_W-1:0] pos_t;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: the timing source drives positions/syncs/strobes, the consumer owns ena.
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int POS_W   = VGA_POS_W,
  parameter int FRAME_W = VGA_FRAME_W
);
  logic               ena;
  logic [POS_W-1:0]   hpos;
  logic [POS_W-1:0]   vpos;
  logic               hsync;
  logic               vsync;
  logic               visible;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  ena,
    output hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
  );

  modport slave (
    output ena,
    input  hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter plus sync/active decode of the next position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP,
  parameter int W      = VGA_POS_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv_i,
  output logic [W-1:0] pos_o,
  output logic         sync_next_o,
  output logic         active_next_o,
  output logic         wrap_o
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (TOTAL > 2**W) begin : g_total_chk
    $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, W);
  end

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);

  logic [W-1:0] pos_q, pos_d;

  assign wrap_o = (pos_q == LAST);

  always_comb begin
    pos_d = pos_q;
    if (adv_i) pos_d = wrap_o ? '0 : pos_q + 1'b1;
  end

  // Decoding pos_d lets the top register sync/active alongside the position they describe.
  assign sync_next_o   = (pos_d >= SYNC_LO) && (pos_d <= SYNC_HI);
  assign active_next_o = (pos_d < ACT_END);

  always_ff @(posedge clk) begin
    if (!rst_n) pos_q <= LAST;
    else        pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: positions, syncs, visible window, line/frame strobes, frame count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = VGA_SYNC_POL,
  parameter int   POS_W    = VGA_POS_W,
  parameter int   FRAME_W  = VGA_FRAME_W
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master tif
);

  logic [POS_W-1:0] h_pos, v_pos;
  logic             h_sync_nx, h_act_nx, h_wrap;
  logic             v_sync_nx, v_act_nx, v_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(POS_W)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .adv_i(tif.ena),
    .pos_o(h_pos), .sync_next_o(h_sync_nx), .active_next_o(h_act_nx), .wrap_o(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(POS_W)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .adv_i(tif.ena && h_wrap),
    .pos_o(v_pos), .sync_next_o(v_sync_nx), .active_next_o(v_act_nx), .wrap_o(v_wrap)
  );

  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               visible_q, visible_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;

  always_comb begin
    hsync_d       = h_sync_nx ? SYNC_POL : ~SYNC_POL;
    vsync_d       = v_sync_nx ? SYNC_POL : ~SYNC_POL;
    visible_d     = h_act_nx && v_act_nx;
    // Strobes come only from an enabled wrap, so a stalled cycle always clears them.
    line_start_d  = tif.ena && h_wrap;
    frame_start_d = line_start_d && v_wrap;
    frame_count_d = frame_start_d ? frame_count_q + 1'b1 : frame_count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '1;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tif.hpos        = h_pos;
  assign tif.vpos        = v_pos;
  assign tif.hsync       = hsync_q;
  assign tif.vsync       = vsync_q;
  assign tif.visible     = visible_q;
  assign tif.line_start  = line_start_q;
  assign tif.frame_start = frame_start_q;
  assign tif.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a shrunk raster (both sync polarities) for frame-level behaviour, plus the full 640x480 config.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.POS_W(10), .FRAME_W(8)) s_if ();
  vga_timing_gen_if #(.POS_W(10), .FRAME_W(8)) p_if ();
  vga_timing_gen_if #(.POS_W(10), .FRAME_W(8)) d_if ();

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b0), .POS_W(10), .FRAME_W(8)
  ) u_small (.clk(clk), .rst_n(rst_n), .tif(s_if));

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b1), .POS_W(10), .FRAME_W(8)
  ) u_pol (.clk(clk), .rst_n(rst_n), .tif(p_if));

  vga_timing_gen u_std (.clk(clk), .rst_n(rst_n), .tif(d_if));

  typedef struct {
    int h, v, hs, vs, vis, ls, fs, fc;
  } exp_t;

  // index 0: shrunk raster, index 1: 640x480
  int cha[2] = '{SHA, 640};
  int chf[2] = '{SHF, 16};
  int chs[2] = '{SHS, 96};
  int cht[2] = '{SHT, 800};
  int cva[2] = '{SVA, 480};
  int cvf[2] = '{SVF, 10};
  int cvs[2] = '{SVS, 2};
  int cvt[2] = '{SVT, 525};

  int mh[2], mv[2], mfc[2];
  exp_t q0[$], q1[$];

  int total = 0, bad = 0;
  int en_cnt = 0, clk_cnt = 0;
  bit have_prev = 0, alt_mode = 0, alt_all = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic predict(input int c, input bit r, input bit e, output exp_t x);
    x.ls = 0;
    x.fs = 0;
    if (!r) begin
      mh[c] = cht[c] - 1;
      mv[c] = cvt[c] - 1;
      mfc[c] = 255;
    end else if (e) begin
      if (mh[c] == cht[c] - 1) begin
        mh[c] = 0;
        x.ls = 1;
        if (mv[c] == cvt[c] - 1) begin
          mv[c] = 0;
          x.fs = 1;
          mfc[c] = (mfc[c] + 1) % 256;
        end else begin
          mv[c] = mv[c] + 1;
        end
      end else begin
        mh[c] = mh[c] + 1;
      end
    end
    x.h   = mh[c];
    x.v   = mv[c];
    x.fc  = mfc[c];
    x.hs  = (mh[c] >= cha[c] + chf[c] && mh[c] < cha[c] + chf[c] + chs[c]) ? 0 : 1;
    x.vs  = (mv[c] >= cva[c] + cvf[c] && mv[c] < cva[c] + cvf[c] + cvs[c]) ? 0 : 1;
    x.vis = (r && mh[c] < cha[c] && mv[c] < cva[c]) ? 1 : 0;
  endtask

  task automatic step(input bit r, input bit e);
    exp_t x0, x1;
    rst_n    = r;
    s_if.ena = e;
    p_if.ena = e;
    d_if.ena = e;
    predict(0, r, e, x0);
    q0.push_back(x0);
    predict(1, r, e, x1);
    q1.push_back(x1);
    @(posedge clk);
    #1;
    x0 = q0.pop_front();
    chk("s_hpos", s_if.hpos, x0.h);
    chk("s_vpos", s_if.vpos, x0.v);
    chk("s_hsync", s_if.hsync, x0.hs);
    chk("s_vsync", s_if.vsync, x0.vs);
    chk("s_visible", s_if.visible, x0.vis);
    chk("s_line_start", s_if.line_start, x0.ls);
    chk("s_frame_start", s_if.frame_start, x0.fs);
    chk("s_frame_count", s_if.frame_count, x0.fc);
    chk("p_hpos", p_if.hpos, x0.h);
    chk("p_vpos", p_if.vpos, x0.v);
    chk("p_hsync", p_if.hsync, 1 - x0.hs);
    chk("p_vsync", p_if.vsync, 1 - x0.vs);
    chk("p_frame_start", p_if.frame_start, x0.fs);
    x1 = q1.pop_front();
    chk("d_hpos", d_if.hpos, x1.h);
    chk("d_vpos", d_if.vpos, x1.v);
    chk("d_hsync", d_if.hsync, x1.hs);
    chk("d_vsync", d_if.vsync, x1.vs);
    chk("d_visible", d_if.visible, x1.vis);
    chk("d_line_start", d_if.line_start, x1.ls);
    chk("d_frame_count", d_if.frame_count, x1.fc);

    // frame_start spacing, measured on the shrunk raster
    if (!r) have_prev = 0;
    if (r && e) en_cnt++;
    clk_cnt++;
    if (!alt_mode) alt_all = 0;
    if (s_if.frame_start === 1'b1) begin
      if (have_prev) begin
        chk("fs_period_en", en_cnt, SHT * SVT);
        if (alt_all) chk("fs_period_alt_clk", clk_cnt, 2 * SHT * SVT);
      end
      have_prev = 1;
      en_cnt    = 0;
      clk_cnt   = 0;
      alt_all   = 1;
    end
  endtask

  initial begin
    int guard;
    s_if.ena = 1'b0;
    p_if.ena = 1'b0;
    d_if.ena = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("first_frame_start", s_if.frame_start, 1);
    chk("first_hpos_std", d_if.hpos, 0);

    for (int i = 0; i < 300; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 500; i++) step(1'b1, $urandom_range(0, 3) != 0);

    alt_mode = 1;
    for (int i = 0; i < 4 * 2 * SHT * SVT; i++) step(1'b1, (i % 2) == 0);
    alt_mode = 0;

    guard = 0;
    while (!(mh[0] == 5 && mv[0] == 2) && guard < 400) begin
      step(1'b1, 1'b1);
      guard++;
    end
    chk("reach_mid_frame", guard < 400, 1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("after_reset_frame_start", s_if.frame_start, 1);

    // long enabled run: frame_count wraps on the shrunk raster, 640x480 sweeps its first lines
    for (int i = 0; i < 260 * SHT * SVT; i++) step(1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
